// File: rtl/fetch_ctrl_01.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator machine.
// It issues memory reads and writes to mem_ctrl_01 and launches operations on alu_01.
module fetch_ctrl_01 #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic [2:0]            alu_op,
  output logic [BUS_WIDTH-1:0]  alu_b,
  output logic                  alu_start,
  input  logic                  alu_done,
  input  logic [BUS_WIDTH-1:0]  alu_result,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPRD, S_ALU, S_STORE, S_HALT
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_STA = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t                state, state_nxt;
  logic [BUS_WIDTH-1:0]  ir;
  logic [BUS_WIDTH-1:0]  alu_b_r;
  logic [BUS_WIDTH-1:0]  wdata_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic                  alu_first;
  logic [2:0]            opcode;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic [ADDR_WIDTH-1:0] pc_prev;
  logic                  jmp_self;

  assign opcode   = ir[BUS_WIDTH-1 -: 3];
  assign ir_addr  = ir[ADDR_WIDTH-1:0];
  // pc has already advanced past the JMP, so a jump to itself targets pc - 1.
  assign pc_prev  = pc_r - ADDR_WIDTH'(1);
  assign jmp_self = (ir_addr == pc_prev);
  assign pc       = pc_r;
  assign alu_b    = alu_b_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_r      <= '0;
      ir        <= '0;
      alu_b_r   <= '0;
      alu_first <= 1'b0;
    end else begin
      state     <= state_nxt;
      alu_first <= (state_nxt == S_ALU) && (state != S_ALU);
      case (state)
        S_FETCH: if (mem_ack) begin
          ir   <= mem_rdata;
          pc_r <= pc_r + ADDR_WIDTH'(1);
        end
        S_DECODE: if (opcode == OP_JMP && !jmp_self) pc_r <= ir_addr;
        S_OPRD:   if (mem_ack) alu_b_r <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Store data is captured on the way into STORE; it is only visible while in STORE.
  always_ff @(posedge clk) begin
    if (state == S_DECODE && opcode == OP_STA) wdata_r <= alu_result;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    alu_op    = 3'b000;
    alu_start = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_r;
        if (mem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_NOP)      state_nxt = S_FETCH;
        else if (opcode == OP_STA) state_nxt = S_STORE;
        else if (opcode == OP_JMP) state_nxt = jmp_self ? S_HALT : S_FETCH;
        else                       state_nxt = S_OPRD;
      end
      S_OPRD: begin
        mem_rd   = 1'b1;
        mem_addr = ir_addr;
        if (mem_ack) state_nxt = S_ALU;
      end
      S_ALU: begin
        alu_op    = opcode;
        alu_start = alu_first;
        if (alu_done && !alu_first) state_nxt = S_FETCH;
      end
      S_STORE: begin
        mem_wr    = 1'b1;
        mem_addr  = ir_addr;
        mem_wdata = wdata_r;
        if (mem_ack) state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl_01.sv
// Directed bench for fetch_ctrl_01 with a one-cycle-latency memory and ALU responder.
module tb_fetch_ctrl_01;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack;
  logic [2:0] alu_op;
  logic [7:0] alu_b;
  logic       alu_start;
  logic       alu_done = 1'b0;
  logic [7:0] alu_result = 8'h00;
  logic [4:0] pc;
  logic       halted;

  logic [7:0] mem [32];
  logic       auto_ack = 1'b1;
  logic       ack_auto = 1'b0;
  logic       ack_man = 1'b0;
  logic [4:0] last_waddr = 5'd0;
  logic [7:0] last_wdata = 8'h00;
  int         wr_count = 0;
  int         total = 0;
  int         bad = 0;

  fetch_ctrl_01 #(.BUS_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_b(alu_b), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  assign mem_ack = auto_ack ? ack_auto : ack_man;

  // Zero-wait responders: ack/done one cycle after the request.
  always @(posedge clk) begin
    ack_auto  <= (mem_rd | mem_wr) && !ack_auto;
    mem_rdata <= mem[mem_addr];
    alu_done  <= alu_start;
    if (mem_wr && mem_ack) begin
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
      wr_count   <= wr_count + 1;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || pc !== 5'd0 || halted !== 1'b0 || alu_start !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d rd=%b wr=%b pc=%0d halted=%b start=%b want 0 0 0 0 0",
                 i, mem_rd, mem_wr, pc, halted, alu_start);
      end
    end
  endtask

  task automatic test_lda();
    run = 1'b1;
    step();
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'd0) begin
      bad++; $display("FAIL lda_fetch rd=%b addr=%0d want 1 0", mem_rd, mem_addr);
    end
    run = 1'b0;
    step();
    total++;
    if (mem_rd !== 1'b1 || mem_ack !== 1'b1) begin
      bad++; $display("FAIL lda_fetch_ack rd=%b ack=%b want 1 1", mem_rd, mem_ack);
    end
    step();
    total++;
    if (mem_rd !== 1'b0 || pc !== 5'd1) begin
      bad++; $display("FAIL lda_decode rd=%b pc=%0d want 0 1", mem_rd, pc);
    end
    step();
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'd5) begin
      bad++; $display("FAIL lda_oprd rd=%b addr=%0d want 1 5", mem_rd, mem_addr);
    end
    step();
    step();
    total++;
    if (alu_start !== 1'b1 || alu_op !== 3'b001 || alu_b !== 8'h07 || mem_rd !== 1'b0) begin
      bad++; $display("FAIL lda_alu_start start=%b op=%b b=%h rd=%b want 1 001 07 0",
                      alu_start, alu_op, alu_b, mem_rd);
    end
    step();
    total++;
    if (alu_start !== 1'b0 || alu_op !== 3'b001 || alu_b !== 8'h07) begin
      bad++; $display("FAIL lda_alu_hold start=%b op=%b b=%h want 0 001 07", alu_start, alu_op, alu_b);
    end
    step();
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'd1 || pc !== 5'd1 || alu_op !== 3'b000) begin
      bad++; $display("FAIL lda_next_fetch rd=%b addr=%0d pc=%0d op=%b want 1 1 1 000",
                      mem_rd, mem_addr, pc, alu_op);
    end
  endtask

  task automatic test_sta();
    step();
    step();
    total++;
    if (pc !== 5'd2 || mem_wr !== 1'b0) begin
      bad++; $display("FAIL sta_decode pc=%0d wr=%b want 2 0", pc, mem_wr);
    end
    step();
    total++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 5'd8 || mem_wdata !== 8'h07) begin
      bad++; $display("FAIL sta_store wr=%b rd=%b addr=%0d wdata=%h want 1 0 8 07",
                      mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    alu_result = 8'h5A;
    step();
    total++;
    if (mem_wr !== 1'b1 || mem_wdata !== 8'h07) begin
      bad++; $display("FAIL sta_hold wr=%b wdata=%h want 1 07", mem_wr, mem_wdata);
    end
    step();
    total++;
    if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 5'd2 || wr_count !== 1 ||
        last_waddr !== 5'd8 || last_wdata !== 8'h07) begin
      bad++; $display("FAIL sta_done wr=%b rd=%b addr=%0d writes=%0d waddr=%0d wdata=%h want 0 1 2 1 8 07",
                      mem_wr, mem_rd, mem_addr, wr_count, last_waddr, last_wdata);
    end
  endtask

  task automatic test_halt();
    step();
    step();
    step();
    total++;
    if (halted !== 1'b1 || pc !== 5'd3 || mem_rd !== 1'b0) begin
      bad++; $display("FAIL halt_enter halted=%b pc=%0d rd=%b want 1 3 0", halted, pc, mem_rd);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (halted !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || pc !== 5'd3) begin
        bad++; $display("FAIL halt_stay cyc=%0d halted=%b rd=%b wr=%b pc=%0d want 1 0 0 3",
                        i, halted, mem_rd, mem_wr, pc);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (halted !== 1'b0 || pc !== 5'd0 || mem_rd !== 1'b0) begin
      bad++; $display("FAIL halt_reset halted=%b pc=%0d rd=%b want 0 0 0", halted, pc, mem_rd);
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 8'hFF;  // JMP 31
    do_reset();
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    total++;
    if (pc !== 5'd1 || mem_rd !== 1'b0) begin
      bad++; $display("FAIL wrap_jmp_decode pc=%0d rd=%b want 1 0", pc, mem_rd);
    end
    step();
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'd31 || pc !== 5'd31) begin
      bad++; $display("FAIL wrap_fetch31 rd=%b addr=%0d pc=%0d want 1 31 31", mem_rd, mem_addr, pc);
    end
    step();
    step();
    total++;
    if (pc !== 5'd0 || mem_rd !== 1'b0 || halted !== 1'b0) begin
      bad++; $display("FAIL wrap_pc pc=%0d rd=%b halted=%b want 0 0 0", pc, mem_rd, halted);
    end
    step();
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'd0) begin
      bad++; $display("FAIL wrap_fetch0 rd=%b addr=%0d want 1 0", mem_rd, mem_addr);
    end
  endtask

  task automatic test_reset_pending();
    clear_mem();
    mem[0] = 8'h25;
    do_reset();
    auto_ack = 1'b0;
    ack_man  = 1'b0;
    run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem_rd !== 1'b1 || mem_addr !== 5'd0) begin
        bad++; $display("FAIL pend_hold cyc=%0d rd=%b addr=%0d want 1 0", i, mem_rd, mem_addr);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    total++;
    if (pc !== 5'd0 || mem_rd !== 1'b0 || halted !== 1'b0) begin
      bad++; $display("FAIL pend_late_ack pc=%0d rd=%b halted=%b want 0 0 0", pc, mem_rd, halted);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pc !== 5'd0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || alu_start !== 1'b0) begin
        bad++; $display("FAIL pend_idle cyc=%0d pc=%0d rd=%b wr=%b start=%b want 0 0 0 0",
                        i, pc, mem_rd, mem_wr, alu_start);
      end
    end
    auto_ack = 1'b1;
  endtask

  initial begin
    clear_mem();
    mem[0] = 8'h25;  // LDA 5
    mem[1] = 8'hC8;  // STA 8
    mem[2] = 8'hE2;  // JMP 2
    mem[5] = 8'h07;
    alu_result = 8'h07;
    test_reset();
    test_lda();
    test_sta();
    test_halt();
    test_wrap();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
